aqfp_phase_sequencer: RTL and testbench
=======================================

# aqfp_phase_sequencer

Synchronous sequencer that drives a pipelined chain of AQFP gate stages (buffers, majority gates, splitters) through a burst of evaluations. It rotates a one-hot multi-phase excitation enable and strobes input loading at stage 0. It strobes output capture once the data has propagated through the configured stage depth, then signals completion. It sits between the test/host controller and the AQFP datapath clock-phase network.

## Interface
- `NPHASE`, 4, number of excitation phases; one phase advances data one gate stage; ≥2
- `DEPTH`, 8, gate stages between input load and output capture; ≥1
- `CNT_W`, 16, width of evaluation count
- `clkin` in 1, single system clock; all logic on rising edge
- `rst_n` in 1, asynchronous active-low reset
- `start` in 1, begin burst; sampled only in IDLE
- `n_evals` in CNT_W, evaluations in burst; latched on accepted `start`
- `abort` in 1, terminate burst immediately
- `stall` in 1, freeze sequencing (present only with `AQFP_SEQ_STALL_EN`)
- `phase_en` out NPHASE, one-hot active excitation phase; 0 when not running
- `in_load` out 1, present next input vector to stage 0 this cycle
- `out_capture` out 1, datapath output valid this cycle
- `busy` out 1, burst in progress
- `done` out 1, one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- IDLE: outputs 0.
  - `start`=1 with `n_evals`>0 latches count, phase pointer p=0, and goes to RUN.
  - `start`=1 with `n_evals`=0 goes to DONE, with no phase activity.
- RUN: `phase_en`=1<<p; p advances by 1 each cycle, wrapping NPHASE-1→0.
  - `in_load`=1 when p==0 and loads_issued < n_evals; loads_issued increments.
  - A DEPTH-bit load-history shift register (shifts each RUN cycle) asserts `out_capture` exactly DEPTH cycles after each `in_load`. Captures may overlap later loads when DEPTH ≥ NPHASE.
  - After the cycle carrying the n-th `out_capture`, go to DONE.
- DONE: `done`=1 for one cycle, `phase_en`=0, then IDLE.
- `busy`=1 in RUN only.
- `start` outside IDLE is ignored; `n_evals` changes after latch have no effect.
- `abort`=1 in RUN or DONE: next state IDLE; all outputs 0 next cycle; no `done`; counters and shift register cleared. `abort` in IDLE has no effect. `abort` has priority over `start` in the same cycle.
- Counters: loads_issued and captures_done are CNT_W bits. They never exceed n_evals, so no wrap. The maximum burst is 2^CNT_W−1.

## Timing
- Reset (async assert, sync release): state IDLE, p=0, counters 0, shift register 0.
  - Outputs `phase_en`=0, `in_load`=0, `out_capture`=0, `busy`=0, `done`=0.
- Reset mid-burst aborts silently, exactly as reset.
- Reference: `start` accepted at edge T. The following hold for k = 0…n−1:
  - RUN begins in cycle T+1.
  - `in_load` is high at cycle T+1+k·NPHASE.
  - `out_capture` is high at cycle T+1+k·NPHASE+DEPTH.
  - `busy` is high over T+1 … T+1+(n−1)·NPHASE+DEPTH.
  - `done` is high at T+2+(n−1)·NPHASE+DEPTH.
- `phase_en` keeps rotating through the drain (after last load) until the last capture cycle inclusive.
- For n_evals=0: `done` at T+1; `busy` stays 0.

## Configuration
- `AQFP_SEQ_STALL_EN` defined: `stall` port exists. In RUN with `stall`=1:
  - p, counters and shift register hold.
  - `phase_en` holds its current value.
  - `in_load`=0 and `out_capture`=0 for that cycle.
  - Sequencing resumes unchanged the cycle after `stall` drops, so all RUN timings extend by the stalled cycle count.
  - `stall` is ignored in IDLE/DONE; `abort` overrides `stall`.
- Undefined: no `stall` port; RUN never pauses.

## Test plan
- Reset with `rst_n`=0 mid-RUN → all outputs 0 asynchronously; after release, `start` with n=2 runs normally from p=0.
- NPHASE=4, DEPTH=8, n=1, `start` at T=0 → `in_load`@1, `phase_en` 0001,0010,0100,1000… from cycle 1, `out_capture`@9, `busy` 1–9, `done`@10.
- n=3, same params → `in_load`@1,5,9; `out_capture`@9,13,17 (load and capture coincide at 9); `done`@18; exactly 3 of each strobe.
- n=0 at T=0 → `done`@1, no `phase_en`/`in_load`/`busy`. `start` pulsed again at cycle 4 during an n=3 burst → ignored, still exactly 3 captures.
- n=3, `abort` at cycle 6 → cycle 7 onward all outputs 0, no `done`, no further captures; a new `start` at cycle 8 begins at p=0.
- With `AQFP_SEQ_STALL_EN`, n=1, `stall` high cycles 3–4 → `phase_en` held at 0100 in cycles 3–4, `out_capture`@11, `done`@12.

Source files
------------

// File: rtl/aqfp_phase_sequencer.sv
// aqfp_phase_sequencer
// Drives a pipelined AQFP gate chain through a burst of evaluations: rotates a
// one-hot excitation phase enable, strobes input loading at stage 0, strobes
// output capture DEPTH cycles after each load, then pulses done.
//
// Ports:
//   clkin        system clock (rising edge)
//   rst_n        asynchronous active-low reset
//   start        begin burst (sampled in IDLE only)
//   n_evals      evaluations in burst, latched on accepted start
//   abort        terminate burst immediately (RUN/DONE)
//   stall        freeze sequencing in RUN (only with AQFP_SEQ_STALL_EN)
//   phase_en     one-hot active excitation phase, 0 when not running
//   in_load      present next input vector to stage 0
//   out_capture  datapath output valid
//   busy         burst in progress
//   done         one-cycle completion pulse
//
// Build option: define AQFP_SEQ_STALL_EN to add the stall port.
module aqfp_phase_sequencer #(
  parameter int unsigned NPHASE = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_evals,
  input  logic              abort,
`ifdef AQFP_SEQ_STALL_EN
  input  logic              stall,
`endif
  output logic [NPHASE-1:0] phase_en,
  output logic              in_load,
  output logic              out_capture,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PW = $clog2(NPHASE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      p_q, p_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   loads_q, loads_d;
  logic [CNT_W-1:0]   caps_q, caps_d;
  logic [DEPTH-1:0]   hist_q, hist_d;
  logic [NPHASE-1:0]  phase_en_q, phase_en_d;
  logic               in_load_q, in_load_d;
  logic               out_capture_q, out_capture_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               run_hold;
  logic [PW-1:0]      p_nxt;
  logic               load_nxt;
  logic               cap_nxt;

`ifdef AQFP_SEQ_STALL_EN
  assign run_hold = stall;
`else
  assign run_hold = 1'b0;
`endif

  // Registers describe the current cycle; lookahead terms describe the next one.
  // hist_q[j] marks a load issued j active cycles before the current one.
  assign p_nxt    = (p_q == PW'(NPHASE - 1)) ? '0 : p_q + PW'(1);
  assign load_nxt = (p_nxt == '0) && (loads_q < n_q);
  assign cap_nxt  = hist_q[DEPTH-1];

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    p_d           = p_q;
    n_d           = n_q;
    loads_d       = loads_q;
    caps_d        = caps_q;
    hist_d        = hist_q;
    phase_en_d    = '0;
    in_load_d     = 1'b0;
    out_capture_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_evals != '0) begin
            state_d    = RUN;
            n_d        = n_evals;
            p_d        = '0;
            loads_d    = CNT_W'(1);
            caps_d     = '0;
            hist_d     = DEPTH'(1);
            phase_en_d = NPHASE'(1);
            in_load_d  = 1'b1;
            busy_d     = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
          p_d     = '0;
          loads_d = '0;
          caps_d  = '0;
          hist_d  = '0;
        end else if (run_hold) begin
          // Frozen: repeat the phase, suppress strobes, keep all counters.
          phase_en_d = phase_en_q;
          busy_d     = 1'b1;
        end else if (caps_q == n_q) begin
          // Current cycle carries the final capture.
          state_d = DONE;
          done_d  = 1'b1;
          p_d     = '0;
          loads_d = '0;
          caps_d  = '0;
          hist_d  = '0;
        end else begin
          p_d           = p_nxt;
          hist_d        = (hist_q << 1) | DEPTH'(load_nxt);
          loads_d       = loads_q + CNT_W'(load_nxt);
          caps_d        = caps_q + CNT_W'(cap_nxt);
          phase_en_d    = NPHASE'(1) << p_nxt;
          in_load_d     = load_nxt;
          out_capture_d = cap_nxt;
          busy_d        = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      p_q           <= '0;
      n_q           <= '0;
      loads_q       <= '0;
      caps_q        <= '0;
      hist_q        <= '0;
      phase_en_q    <= '0;
      in_load_q     <= 1'b0;
      out_capture_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      n_q           <= n_d;
      loads_q       <= loads_d;
      caps_q        <= caps_d;
      hist_q        <= hist_d;
      phase_en_q    <= phase_en_d;
      in_load_q     <= in_load_d;
      out_capture_q <= out_capture_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign phase_en    = phase_en_q;
  assign in_load     = in_load_q;
  assign out_capture = out_capture_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_aqfp_phase_sequencer.sv
// Directed bench for aqfp_phase_sequencer (NPHASE=4, DEPTH=8).
// Cycle c output = value just after edge c; an input driven during cycle c is
// sampled at edge c+1. A start driven in cycle 0 yields RUN from cycle 1.
module tb_aqfp_phase_sequencer;

  localparam int unsigned NP = 4;
  localparam int unsigned DP = 8;
  localparam int unsigned CW = 16;

  logic          clkin;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] n_evals;
  logic          abort;
  logic          stall;
  logic [NP-1:0] phase_en;
  logic          in_load;
  logic          out_capture;
  logic          busy;
  logic          done;

  int total;
  int bad;

  aqfp_phase_sequencer #(.NPHASE(NP), .DEPTH(DP), .CNT_W(CW)) dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .start       (start),
    .n_evals     (n_evals),
    .abort       (abort),
`ifdef AQFP_SEQ_STALL_EN
    .stall       (stall),
`endif
    .phase_en    (phase_en),
    .in_load     (in_load),
    .out_capture (out_capture),
    .busy        (busy),
    .done        (done)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Expected {phase_en, in_load, out_capture, busy, done} in cycle c of an
  // uninterrupted burst of n evaluations started in cycle 0.
  function automatic logic [7:0] model(int n, int c);
    int   last;
    logic [3:0] ph;
    logic ld, cp, bz, dn;
    last = 1 + (n - 1) * NP + DP;
    bz   = (c >= 1) && (c <= last);
    ph   = bz ? (4'b0001 << ((c - 1) % NP)) : 4'b0000;
    ld   = bz && ((c - 1) % NP == 0) && ((c - 1) / NP < n);
    cp   = (c >= 1 + DP) && (c <= last) && ((c - 1 - DP) % NP == 0);
    dn   = (c == last + 1);
    return {ph, ld, cp, bz, dn};
  endfunction

  function automatic logic [7:0] obs();
    return {phase_en, in_load, out_capture, busy, done};
  endfunction

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0; start = 1'b0; n_evals = '0; abort = 1'b0; stall = 1'b0;
    #2;
    got = obs();
    total++;
    if (got !== 8'h00) begin
      bad++; $display("FAIL reset_init got=%h want=00", got);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // Start a burst, then pull reset between edges.
    start = 1'b1; n_evals = 16'd2;
    tick(); start = 1'b0;
    tick(); tick();
    #3;
    rst_n = 1'b0;
    #1;
    got = obs();
    total++;
    if (got !== 8'h00) begin
      bad++; $display("FAIL reset_async got=%h want=00", got);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1; n_evals = 16'd2;
    for (int c = 1; c <= 15; c++) begin
      tick(); start = 1'b0;
      got = obs();
      total++;
      if (got !== model(2, c)) begin
        bad++; $display("FAIL reset_rerun c=%0d got=%h want=%h", c, got, model(2, c));
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] got;
    tick();
    start = 1'b1; n_evals = 16'd1;
    for (int c = 1; c <= 13; c++) begin
      tick(); start = 1'b0;
      got = obs();
      total++;
      if (got !== model(1, c)) begin
        bad++; $display("FAIL single c=%0d got=%h want=%h", c, got, model(1, c));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    int loads, caps;
    loads = 0; caps = 0;
    tick();
    start = 1'b1; n_evals = 16'd3;
    for (int c = 1; c <= 21; c++) begin
      tick(); start = 1'b0;
      got = obs();
      loads += int'(in_load);
      caps  += int'(out_capture);
      total++;
      if (got !== model(3, c)) begin
        bad++; $display("FAIL multi c=%0d got=%h want=%h", c, got, model(3, c));
      end
      // Re-start with a different count mid-burst: must be ignored.
      if (c == 4) begin
        start = 1'b1; n_evals = 16'd7;
      end
    end
    total++;
    if (loads != 3) begin
      bad++; $display("FAIL multi_loads got=%0d want=3", loads);
    end
    total++;
    if (caps != 3) begin
      bad++; $display("FAIL multi_caps got=%0d want=3", caps);
    end
  endtask

  task automatic test_zero();
    logic [7:0] got;
    logic [7:0] want;
    tick();
    start = 1'b1; n_evals = 16'd0;
    for (int c = 1; c <= 4; c++) begin
      tick(); start = 1'b0;
      got  = obs();
      want = (c == 1) ? 8'h01 : 8'h00;
      total++;
      if (got !== want) begin
        bad++; $display("FAIL zero c=%0d got=%h want=%h", c, got, want);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    logic [7:0] want;
    tick();
    start = 1'b1; n_evals = 16'd3;
    for (int c = 1; c <= 20; c++) begin
      tick(); start = 1'b0; abort = 1'b0;
      got = obs();
      if (c <= 6)      want = model(3, c);
      else if (c <= 8) want = 8'h00;
      else             want = model(1, c - 8);
      total++;
      if (got !== want) begin
        bad++; $display("FAIL abort c=%0d got=%h want=%h", c, got, want);
      end
      if (c == 6) abort = 1'b1;
      if (c == 8) begin
        start = 1'b1; n_evals = 16'd1;
      end
    end
  endtask

`ifdef AQFP_SEQ_STALL_EN
  task automatic test_stall();
    logic [7:0] got;
    logic [7:0] want;
    tick();
    start = 1'b1; n_evals = 16'd1;
    for (int c = 1; c <= 15; c++) begin
      tick(); start = 1'b0;
      got = obs();
      if (c <= 3)      want = model(1, c);
      else if (c <= 5) want = 8'b0100_0010;
      else             want = model(1, c - 2);
      total++;
      if (got !== want) begin
        bad++; $display("FAIL stall c=%0d got=%h want=%h", c, got, want);
      end
      stall = (c == 3) || (c == 4);
    end
    stall = 1'b0;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero();
    test_abort();
`ifdef AQFP_SEQ_STALL_EN
    test_stall();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
